// File: rtl/plru_victim_alloc_if.sv
// Bundle of the victim-allocation handshake, lookup-hit, refill and PLRU-tree signals.
// The slave modport is the allocator; the master modport is the surrounding TLB/cache logic.
interface plru_victim_alloc_if #(
    parameter int ENTRIES = 16
);
    localparam int IdxW = $clog2(ENTRIES);

    logic                flush_i;
    logic                lookup_hit_i;
    logic [ENTRIES-1:0]  lookup_hit_oh_i;
    logic                alloc_req_i;
    logic                alloc_gnt_o;
    logic [IdxW-1:0]     alloc_idx_o;
    logic [ENTRIES-1:0]  alloc_oh_o;
    logic                fill_valid_i;
    logic                fill_abort_i;
    logic                fill_ready_o;
    logic                busy_o;
    logic [ENTRIES-1:0]  valid_o;
    logic [ENTRIES-1:0]  plru_i;
    logic [ENTRIES-1:0]  used_o;

    modport master (
        output flush_i, lookup_hit_i, lookup_hit_oh_i, alloc_req_i,
               fill_valid_i, fill_abort_i, plru_i,
        input  alloc_gnt_o, alloc_idx_o, alloc_oh_o, fill_ready_o,
               busy_o, valid_o, used_o
    );

    modport slave (
        input  flush_i, lookup_hit_i, lookup_hit_oh_i, alloc_req_i,
               fill_valid_i, fill_abort_i, plru_i,
        output alloc_gnt_o, alloc_idx_o, alloc_oh_o, fill_ready_o,
               busy_o, valid_o, used_o
    );
endinterface

// File: rtl/plru_victim_alloc.sv
// Picks a refill victim (first invalid entry, else the PLRU choice), tracks the refill,
// and produces the one-hot recency update consumed by the PLRU tree.
module plru_victim_alloc #(
    parameter int ENTRIES = 16
) (
    input  logic                 clk_i,
    input  logic                 rst_ni,
    plru_victim_alloc_if.slave   bus
);
    localparam int IdxW = $clog2(ENTRIES);

    typedef enum logic {
        IDLE,
        FILL
    } state_e;

    state_e              state_q;
    logic [ENTRIES-1:0]  valid_q;
    logic [ENTRIES-1:0]  oh_q;
    logic [IdxW-1:0]     idx_q;
    logic                gnt_q;

    logic [IdxW-1:0]     victim_idx;
    logic [ENTRIES-1:0]  victim_oh;
    logic                any_invalid;
    logic                fill_done;

    // Downward scans leave the lowest matching index; a zero PLRU vector falls back to entry 0.
    always_comb begin
        victim_idx  = '0;
        any_invalid = 1'b0;
        for (int i = ENTRIES - 1; i >= 0; i--) begin
            if (!valid_q[i]) begin
                victim_idx  = IdxW'(i);
                any_invalid = 1'b1;
            end
        end
        if (!any_invalid) begin
            for (int i = ENTRIES - 1; i >= 0; i--) begin
                if (bus.plru_i[i]) begin
                    victim_idx = IdxW'(i);
                end
            end
        end
    end

    assign victim_oh = {{(ENTRIES-1){1'b0}}, 1'b1} << victim_idx;
    assign fill_done = (state_q == FILL) && bus.fill_valid_i && !bus.flush_i;

    always_comb begin
        bus.used_o = '0;
        if (bus.flush_i) begin
            bus.used_o = '0;
        end else if (fill_done) begin
            bus.used_o = oh_q;
        end else if (bus.lookup_hit_i) begin
            bus.used_o = bus.lookup_hit_oh_i & valid_q;
        end
    end

    assign bus.alloc_gnt_o  = gnt_q;
    assign bus.alloc_idx_o  = idx_q;
    assign bus.alloc_oh_o   = oh_q;
    assign bus.busy_o       = (state_q == FILL);
    assign bus.fill_ready_o = (state_q == FILL);
    assign bus.valid_o      = valid_q;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= IDLE;
            valid_q <= '0;
            oh_q    <= '0;
            idx_q   <= '0;
            gnt_q   <= 1'b0;
        end else if (bus.flush_i) begin
            state_q <= IDLE;
            valid_q <= '0;
            gnt_q   <= 1'b0;
        end else begin
            gnt_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (bus.alloc_req_i) begin
                        idx_q   <= victim_idx;
                        oh_q    <= victim_oh;
                        valid_q <= valid_q & ~victim_oh;
                        gnt_q   <= 1'b1;
                        state_q <= FILL;
                    end
                end
                FILL: begin
                    if (bus.fill_valid_i) begin
                        valid_q <= valid_q | oh_q;
                        state_q <= IDLE;
                    end else if (bus.fill_abort_i) begin
                        state_q <= IDLE;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_plru_victim_alloc.sv
// Self-checking bench for plru_victim_alloc with ENTRIES=4; expected victims go through a
// scoreboard queue that is drained whenever the DUT raises alloc_gnt_o.
module tb_plru_victim_alloc;
    localparam int ENTRIES = 4;

    logic clk;
    logic rstN;
    int   testsRun;
    int   testsFailed;
    int   expQ[$];

    plru_victim_alloc_if #(.ENTRIES(ENTRIES)) bus ();

    plru_victim_alloc #(.ENTRIES(ENTRIES)) dut (
        .clk_i  (clk),
        .rst_ni (rstN),
        .bus    (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Requests a victim, waits (bounded) for the grant and checks it against the scoreboard.
    task automatic allocAndCheck(input int expIdx, input string name);
        int cyc;
        int exp;
        logic [ENTRIES-1:0] expOh;
        expQ.push_back(expIdx);
        bus.alloc_req_i = 1'b1;
        cyc = 0;
        do begin
            tick();
            cyc++;
        end while (!bus.alloc_gnt_o && cyc < 8);
        bus.alloc_req_i = 1'b0;
        testsRun++;
        if (cyc !== 1 || bus.alloc_gnt_o !== 1'b1) begin
            testsFailed++;
            $display("[TB] FAIL %s_gnt_latency: got %0d cycles (gnt=%b), expected 1 cycle", name, cyc, bus.alloc_gnt_o);
        end
        exp = (expQ.size() > 0) ? expQ.pop_front() : 0;
        expOh = 4'b0001 << exp;
        testsRun++;
        if (bus.alloc_idx_o !== 2'(exp) || bus.alloc_oh_o !== expOh) begin
            testsFailed++;
            $display("[TB] FAIL %s_victim: got idx %0d oh %b, expected idx %0d oh %b", name, bus.alloc_idx_o, bus.alloc_oh_o, exp, expOh);
        end
    endtask

    task automatic driveFill();
        bus.fill_valid_i = 1'b1;
        tick();
        bus.fill_valid_i = 1'b0;
    endtask

    task automatic test_reset();
        rstN = 1'b0;
        repeat (2) @(negedge clk);
        testsRun++;
        if ({bus.valid_o, bus.alloc_gnt_o, bus.alloc_idx_o, bus.alloc_oh_o, bus.fill_ready_o, bus.busy_o, bus.used_o} !== '0) begin
            testsFailed++;
            $display("[TB] FAIL reset_values: got valid %b gnt %b idx %0d oh %b rdy %b busy %b used %b, expected all 0", bus.valid_o, bus.alloc_gnt_o, bus.alloc_idx_o, bus.alloc_oh_o, bus.fill_ready_o, bus.busy_o, bus.used_o);
        end
        tick();
        rstN = 1'b1;
        tick();
    endtask

    task automatic test_fill_sequence();
        for (int k = 0; k < 3; k++) begin
            allocAndCheck(k, "seq");
            testsRun++;
            if (bus.busy_o !== 1'b1 || bus.fill_ready_o !== 1'b1) begin
                testsFailed++;
                $display("[TB] FAIL seq_busy: got busy %b ready %b, expected 1 1", bus.busy_o, bus.fill_ready_o);
            end
            bus.fill_valid_i = 1'b1;
            @(negedge clk);
            testsRun++;
            if (bus.used_o !== (4'b0001 << k)) begin
                testsFailed++;
                $display("[TB] FAIL seq_used: got %b, expected %b", bus.used_o, 4'b0001 << k);
            end
            tick();
            bus.fill_valid_i = 1'b0;
        end
        testsRun++;
        if (bus.valid_o !== 4'b0111 || bus.busy_o !== 1'b0) begin
            testsFailed++;
            $display("[TB] FAIL seq_valid: got valid %b busy %b, expected 0111 0", bus.valid_o, bus.busy_o);
        end
    endtask

    task automatic test_plru_victim();
        allocAndCheck(3, "fill3");
        driveFill();
        bus.plru_i = 4'b0100;
        allocAndCheck(2, "plru");
        testsRun++;
        if (bus.valid_o !== 4'b1011) begin
            testsFailed++;
            $display("[TB] FAIL plru_valid_during_fill: got %b, expected 1011", bus.valid_o);
        end
        bus.lookup_hit_i    = 1'b1;
        bus.lookup_hit_oh_i = 4'b0100;
        @(negedge clk);
        testsRun++;
        if (bus.used_o !== 4'b0000) begin
            testsFailed++;
            $display("[TB] FAIL plru_hit_masked: got %b, expected 0000", bus.used_o);
        end
        tick();
        bus.lookup_hit_i = 1'b0;
        testsRun++;
        if (bus.alloc_gnt_o !== 1'b0 || bus.busy_o !== 1'b1) begin
            testsFailed++;
            $display("[TB] FAIL plru_second_fill_cycle: got gnt %b busy %b, expected 0 1", bus.alloc_gnt_o, bus.busy_o);
        end
        bus.fill_valid_i = 1'b1;
        @(negedge clk);
        testsRun++;
        if (bus.used_o !== 4'b0100) begin
            testsFailed++;
            $display("[TB] FAIL plru_fill_used: got %b, expected 0100", bus.used_o);
        end
        tick();
        bus.fill_valid_i = 1'b0;
        testsRun++;
        if (bus.valid_o !== 4'b1111) begin
            testsFailed++;
            $display("[TB] FAIL plru_valid_after: got %b, expected 1111", bus.valid_o);
        end
    endtask

    task automatic test_fill_vs_hit();
        bus.plru_i = 4'b0100;
        allocAndCheck(2, "fvh");
        bus.fill_valid_i    = 1'b1;
        bus.lookup_hit_i    = 1'b1;
        bus.lookup_hit_oh_i = 4'b0001;
        @(negedge clk);
        testsRun++;
        if (bus.used_o !== 4'b0100) begin
            testsFailed++;
            $display("[TB] FAIL fvh_fill_wins: got %b, expected 0100", bus.used_o);
        end
        tick();
        bus.fill_valid_i = 1'b0;
        @(negedge clk);
        testsRun++;
        if (bus.used_o !== 4'b0001) begin
            testsFailed++;
            $display("[TB] FAIL fvh_hit_next: got %b, expected 0001", bus.used_o);
        end
        tick();
        bus.lookup_hit_i = 1'b0;
    endtask

    task automatic test_abort();
        bus.plru_i = 4'b0010;
        allocAndCheck(1, "abort");
        bus.fill_abort_i = 1'b1;
        @(negedge clk);
        testsRun++;
        if (bus.used_o !== 4'b0000) begin
            testsFailed++;
            $display("[TB] FAIL abort_used: got %b, expected 0000", bus.used_o);
        end
        tick();
        bus.fill_abort_i = 1'b0;
        testsRun++;
        if (bus.busy_o !== 1'b0 || bus.valid_o !== 4'b1101) begin
            testsFailed++;
            $display("[TB] FAIL abort_state: got busy %b valid %b, expected 0 1101", bus.busy_o, bus.valid_o);
        end
        bus.plru_i = 4'b1000;
        allocAndCheck(1, "abort_realloc");
        driveFill();
    endtask

    task automatic test_flush();
        bus.plru_i = 4'b0001;
        allocAndCheck(0, "flush");
        bus.flush_i      = 1'b1;
        bus.fill_valid_i = 1'b1;
        @(negedge clk);
        testsRun++;
        if (bus.used_o !== 4'b0000) begin
            testsFailed++;
            $display("[TB] FAIL flush_used: got %b, expected 0000", bus.used_o);
        end
        tick();
        bus.flush_i      = 1'b0;
        bus.fill_valid_i = 1'b0;
        testsRun++;
        if (bus.valid_o !== 4'b0000 || bus.busy_o !== 1'b0) begin
            testsFailed++;
            $display("[TB] FAIL flush_state: got valid %b busy %b, expected 0000 0", bus.valid_o, bus.busy_o);
        end
    endtask

    // Request held through a zero-wait fill: grants land two cycles apart.
    task automatic test_back_to_back();
        allocAndCheck(0, "b2b_first");
        expQ.push_back(1);
        bus.alloc_req_i  = 1'b1;
        bus.fill_valid_i = 1'b1;
        tick();
        bus.fill_valid_i = 1'b0;
        testsRun++;
        if (bus.alloc_gnt_o !== 1'b0 || bus.busy_o !== 1'b0) begin
            testsFailed++;
            $display("[TB] FAIL b2b_idle_gap: got gnt %b busy %b, expected 0 0", bus.alloc_gnt_o, bus.busy_o);
        end
        tick();
        bus.alloc_req_i = 1'b0;
        begin
            int exp;
            exp = (expQ.size() > 0) ? expQ.pop_front() : 0;
            testsRun++;
            if (bus.alloc_gnt_o !== 1'b1 || bus.alloc_idx_o !== 2'(exp)) begin
                testsFailed++;
                $display("[TB] FAIL b2b_second_gnt: got gnt %b idx %0d, expected 1 %0d", bus.alloc_gnt_o, bus.alloc_idx_o, exp);
            end
        end
        driveFill();
    endtask

    task automatic test_reset_mid_fill();
        allocAndCheck(2, "rst_fill2");
        driveFill();
        allocAndCheck(3, "rst_fill3");
        driveFill();
        bus.plru_i = 4'b0000;
        allocAndCheck(0, "plru_zero");
        #2;
        rstN = 1'b0;
        #1;
        testsRun++;
        if (bus.busy_o !== 1'b0 || bus.fill_ready_o !== 1'b0 || bus.valid_o !== 4'b0000 || bus.alloc_gnt_o !== 1'b0 || bus.alloc_oh_o !== 4'b0000) begin
            testsFailed++;
            $display("[TB] FAIL async_reset: got busy %b rdy %b valid %b gnt %b oh %b, expected 0 0 0000 0 0000", bus.busy_o, bus.fill_ready_o, bus.valid_o, bus.alloc_gnt_o, bus.alloc_oh_o);
        end
        tick();
        rstN = 1'b1;
        tick();
    endtask

    initial begin
        testsRun    = 0;
        testsFailed = 0;
        rstN                = 1'b0;
        bus.flush_i         = 1'b0;
        bus.lookup_hit_i    = 1'b0;
        bus.lookup_hit_oh_i = '0;
        bus.alloc_req_i     = 1'b0;
        bus.fill_valid_i    = 1'b0;
        bus.fill_abort_i    = 1'b0;
        bus.plru_i          = '0;

        test_reset();
        test_fill_sequence();
        test_plru_victim();
        test_fill_vs_hit();
        test_abort();
        test_flush();
        test_back_to_back();
        test_reset_mid_fill();

        $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
        $finish;
    end
endmodule

// File: doc/plru_victim_alloc.md
# plru_victim_alloc

Victim-selection and refill-tracking stage wrapped around the PLRU tree in the TLB/cache replacement path. Keeps per-entry valid bits, picks an invalid entry for a refill or, when all entries are valid, the PLRU one-hot supplied by the tree. Tracks the outstanding refill with a small FSM and produces the one-hot `used` update the tree consumes on lookup hits and refill completion.

## Interface
- ENTRIES, 16, number of entries; power of two, ≥2
- IdxW (localparam), $clog2(ENTRIES), binary index width
- clk_i  in  1  clock
- rst_ni  in  1  reset, asynchronous, active-low
- flush_i  in  1  invalidate all entries; aborts outstanding refill
- lookup_hit_i  in  1  a lookup hit this cycle
- lookup_hit_oh_i  in  ENTRIES  one-hot hit entry, qualified by lookup_hit_i
- alloc_req_i  in  1  refill needs a victim; held until alloc_gnt_o
- alloc_gnt_o  out  1  one-cycle grant; alloc_idx_o valid
- alloc_idx_o  out  IdxW  binary victim index, stable while busy_o
- alloc_oh_o  out  ENTRIES  one-hot victim, stable while busy_o
- fill_valid_i  in  1  refill data written to victim
- fill_abort_i  in  1  refill failed; victim stays invalid
- fill_ready_o  out  1  refill completion accepted (FILL state)
- busy_o  out  1  refill outstanding
- valid_o  out  ENTRIES  per-entry valid bits
- plru_i  in  ENTRIES  one-hot LRU entry from the PLRU tree
- used_o  out  ENTRIES  one-hot recency update to the PLRU tree

## Operation
- FSM states: IDLE, FILL.
- IDLE, alloc_req_i=1, flush_i=0: victim = lowest-index entry with valid=0; if none, victim = plru_i; if plru_i=0 use entry 0; if plru_i has several bits use lowest set bit. Latch victim into alloc_idx_o/alloc_oh_o, clear valid[victim], go FILL.
- FILL: alloc_gnt_o=1 in first FILL cycle only. fill_ready_o=1, busy_o=1 throughout. alloc_req_i ignored.
- FILL, fill_valid_i=1: set valid[victim] next cycle, used_o=alloc_oh_o same cycle, go IDLE.
- FILL, fill_abort_i=1 (fill_valid_i=0): go IDLE, valid unchanged, no used_o. fill_valid_i and fill_abort_i together: fill_valid_i wins.
- fill_valid_i/fill_abort_i outside FILL: ignored.
- used_o otherwise = lookup_hit_oh_i & valid_o when lookup_hit_i=1, else 0. Hits on invalid entries are masked.
- Fill completion and lookup hit in same cycle: fill wins, hit dropped. used_o always zero or one-hot.
- flush_i: valid_o=0 next cycle, state to IDLE, used_o=0 that cycle, alloc_req_i not sampled that cycle. Flush beats fill_valid_i (entry stays invalid).
- Reset mid-refill: back to IDLE, all outputs to reset values.

## Timing
- Reset values: state IDLE, valid_o=0, alloc_gnt_o=0, alloc_idx_o=0, alloc_oh_o=0, fill_ready_o=0, busy_o=0, used_o=0.
- alloc_req_i sampled in cycle N → alloc_gnt_o, busy_o high in N+1; victim from plru_i/valid_o as of cycle N.
- alloc_gnt_o, fill_ready_o, busy_o, alloc_idx_o, alloc_oh_o, valid_o registered.
- used_o combinational from inputs and state, same cycle; the tree reflects it one cycle later.
- Earliest back-to-back: fill_valid_i in N+1 → IDLE in N+2 → next grant N+3.
- Minimum refill occupancy: one FILL cycle.

## Test plan
- ENTRIES=4, after reset: alloc_req_i three times with immediate fill_valid_i → victims 0,1,2; gnt one cycle after each req; used_o=0001,0010,0100 on the fills; valid_o=0111.
- All valid, plru_i=0100, alloc_req_i → alloc_idx_o=2, alloc_oh_o=0100, valid_o=1011 during FILL; lookup_hit_oh_i=0100 masked (used_o=0); fill_valid_i → used_o=0100, valid_o=1111.
- FILL with fill_valid_i and lookup_hit_oh_i=0001 in same cycle → used_o=0100 only; next cycle with hit → used_o=0001.
- fill_abort_i in FILL → IDLE, valid_o keeps victim cleared, used_o=0; next alloc_req_i picks that entry.
- flush_i together with fill_valid_i in FILL → valid_o=0000, used_o=0, busy_o=0 next cycle.
- rst_ni low mid-FILL → busy_o=0, fill_ready_o=0, valid_o=0 immediately (async); plru_i=0 with all valid → victim 0.
